id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the MIPS datapath. It sits directly downstream of the main control decoder and register file, and captures the decoder's control bundle plus the operand fields each cycle. It contains load-use hazard detection, which inserts a one-cycle bubble and stalls PC and IF/ID. It also honours a branch flush from EX/MEM.

Parameters:
DATA_W, 32, width of register operands, immediate and PC+4
REG_AW, 5, register-number width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_addi_op  in  1 each  decoder control bits
id_alu_op  in  2  decoder ALUOp
id_funct  in  6  instr[5:0]
id_rs, id_rt, id_rd  in  REG_AW  instr[25:21], [20:16], [15:11]
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of the ID instruction
flush  in  1  branch taken in EX/MEM; kill the ID instruction
ex_valid  out  1  EX holds a real instruction
ex_reg_dst … ex_addi_op, ex_alu_op  out  same widths  registered control bundle
ex_funct, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  same widths  registered fields
ex_dst_reg  out  REG_AW  registered (id_reg_dst ? id_rd : id_rt)
stall  out  1  load-use bubble being inserted this cycle (combinational)
pc_write  out  1  ~stall
if_id_write  out  1  ~stall

Behaviour:
- Reset: all ex_* outputs are 0 and ex_valid is 0. Consequently stall=0 and pc_write=if_id_write=1 in the cycle after reset.
- id_uses_rt = id_reg_dst | id_mem_write | id_branch (R-type, sw, beq).
- load_use = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- stall = load_use & ~flush. It is purely combinational with no added latency.
- Register update priority per rising edge:
  1. rst: clear everything.
  2. flush: ex_valid=0, all control bits and ex_dst_reg = 0; data fields hold.
  3. load_use: bubble. ex_valid=0, controls=0, data fields hold.
  4. otherwise capture: ex_* <= id_*, ex_valid <= id_valid. If id_valid=0, controls are forced to 0.
- Latency: one cycle from ID to EX.
- The bubble clears ex_valid, so a stall lasts exactly one cycle. The stalled instruction is captured on the following edge.
- flush and load_use in the same cycle: flush wins and stall=0. IF/ID is flushed upstream anyway.
- A nop (all-zero instruction) arriving with reg_write=0 passes as valid with no side effects.
- Reset asserted during a stall: clears everything on that edge; no bubble is carried over.

Optional Feature:
Macro ID_EX_PERF_EN.
- Defined: adds outputs bubble_cnt [31:0] and flush_cnt [31:0].
  - bubble_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where flush=1 and the pre-edge id_valid=1.
  - Both saturate at 0xFFFF_FFFF and clear on rst.
- Not defined: ports and counters are absent; pipeline behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - ctrl_t packed struct (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0], addi_op)
  - CTRL_NOP constant (all zero)
  - opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_ADDI=6'h08
- One sub-module: load_use_detect, combinational, producing load_use from the ex_/id_ fields.

Test Plan:
1. rst=1 for 2 cycles, then release → all ex_* = 0, ex_valid=0, stall=0, pc_write=1.
2. addi $1,$0,5 then add $2,$1,$1 in consecutive cycles → ex fields follow one cycle later; ex_dst_reg=1 then 2; stall never asserts.
3. lw $3,0($0) in EX, add $4,$3,$5 in ID → stall=1 for exactly one cycle; EX gets a bubble (ex_valid=0, ex_reg_write=0); the add enters EX on the next edge.
4. lw $0,… in EX with add using $0 in ID → no stall. lw $3 in EX with addi $6,$3,1 in ID → stall. lw $3 in EX with addi $3,$7,1 in ID (rt is the destination, id_uses_rt=0) → no stall.
5. Load-use condition and flush=1 in the same cycle → stall=0; next cycle ex_valid=0 and controls=0.
6. With ID_EX_PERF_EN: 3 load-use stalls and 2 flushes of valid instructions → bubble_cnt=3, flush_cnt=2; rst → both 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: decoder control bundle, opcodes and helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       addi_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(10'd0);

    // Instructions that read rt as a source: R-type, sw, beq.
    function automatic logic uses_rt(input logic reg_dst, input logic mem_write,
                                     input logic branch);
        return reg_dst | mem_write | branch;
    endfunction

    // Reference main-decoder mapping from opcode to control bundle.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = 2'b10;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = 2'b01;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.addi_op   = 1'b1;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose rt is a source of the ID instruction.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_reg_dst,
    input  logic              id_mem_write,
    input  logic              id_branch,
    output logic              load_use
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Compare the in-flight load destination against the ID source registers.
    always_comb begin
        rs_hit_s = (ex_rt == id_rs);
        rt_hit_s = uses_rt(id_reg_dst, id_mem_write, id_branch) && (ex_rt == id_rt);
        if (ex_valid && ex_mem_read && (ex_rt != {REG_AW{1'b0}}) && id_valid) begin
            load_use = rs_hit_s | rt_hit_s;
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional performance counters enabled by defining ID_EX_PERF_EN.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic              id_mem_to_reg,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_addi_op,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_addi_op,
    output logic [1:0]        ex_alu_op,
    output logic [5:0]        ex_funct,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_dst_reg,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write
);

    ctrl_t             id_ctrl_s;
    ctrl_t             ctrl_r;
    logic              valid_r;
    logic [5:0]        funct_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] rd_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [DATA_W-1:0] imm_r;
    logic [DATA_W-1:0] pc4_r;
    logic [REG_AW-1:0] dst_r;
    logic              load_use_s;
    logic              stall_s;

    assign id_ctrl_s = '{reg_dst:    id_reg_dst,
                         alu_src:    id_alu_src,
                         mem_to_reg: id_mem_to_reg,
                         reg_write:  id_reg_write,
                         mem_read:   id_mem_read,
                         mem_write:  id_mem_write,
                         branch:     id_branch,
                         alu_op:     id_alu_op,
                         addi_op:    id_addi_op};

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .ex_valid    (valid_r),
        .ex_mem_read (ctrl_r.mem_read),
        .ex_rt       (rt_r),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_reg_dst  (id_reg_dst),
        .id_mem_write(id_mem_write),
        .id_branch   (id_branch),
        .load_use    (load_use_s)
    );

    // A flush kills the ID instruction, so there is nothing left to stall for.
    assign stall_s     = load_use_s & ~flush;
    assign stall       = stall_s;
    assign pc_write    = ~stall_s;
    assign if_id_write = ~stall_s;

    // Pipeline register: reset, then flush, then bubble, then normal capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            ctrl_r    <= CTRL_NOP;
            funct_r   <= 6'd0;
            rs_r      <= {REG_AW{1'b0}};
            rt_r      <= {REG_AW{1'b0}};
            rd_r      <= {REG_AW{1'b0}};
            rs_data_r <= {DATA_W{1'b0}};
            rt_data_r <= {DATA_W{1'b0}};
            imm_r     <= {DATA_W{1'b0}};
            pc4_r     <= {DATA_W{1'b0}};
            dst_r     <= {REG_AW{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
            ctrl_r  <= CTRL_NOP;
            dst_r   <= {REG_AW{1'b0}};
        end else if (load_use_s) begin
            valid_r <= 1'b0;
            ctrl_r  <= CTRL_NOP;
        end else begin
            valid_r   <= id_valid;
            ctrl_r    <= id_valid ? id_ctrl_s : CTRL_NOP;
            funct_r   <= id_funct;
            rs_r      <= id_rs;
            rt_r      <= id_rt;
            rd_r      <= id_rd;
            rs_data_r <= id_rs_data;
            rt_data_r <= id_rt_data;
            imm_r     <= id_imm;
            pc4_r     <= id_pc4;
            dst_r     <= id_reg_dst ? id_rd : id_rt;
        end
    end

    assign ex_valid      = valid_r;
    assign ex_reg_dst    = ctrl_r.reg_dst;
    assign ex_alu_src    = ctrl_r.alu_src;
    assign ex_mem_to_reg = ctrl_r.mem_to_reg;
    assign ex_reg_write  = ctrl_r.reg_write;
    assign ex_mem_read   = ctrl_r.mem_read;
    assign ex_mem_write  = ctrl_r.mem_write;
    assign ex_branch     = ctrl_r.branch;
    assign ex_alu_op     = ctrl_r.alu_op;
    assign ex_addi_op    = ctrl_r.addi_op;
    assign ex_funct      = funct_r;
    assign ex_rs         = rs_r;
    assign ex_rt         = rt_r;
    assign ex_rd         = rd_r;
    assign ex_rs_data    = rs_data_r;
    assign ex_rt_data    = rt_data_r;
    assign ex_imm        = imm_r;
    assign ex_pc4        = pc4_r;
    assign ex_dst_reg    = dst_r;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating event counters for inserted bubbles and killed valid instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= 32'd0;
            flush_cnt_r  <= 32'd0;
        end else begin
            if (stall_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (flush && id_valid && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state is queued at drive time and
// compared one edge later; stall/pc_write/if_id_write are checked combinationally.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [9:0]  ctrl;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  dst;
    } ex_t;

    // ctrl bit order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch alu_op[1:0] addi_op
    localparam logic [9:0] C_R    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
    localparam logic [9:0] C_LW   = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam logic [9:0] C_SW   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    localparam logic [9:0] C_BEQ  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    localparam logic [9:0] C_ADDI = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    localparam logic [9:0] C_NOP  = 10'd0;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_ctrl;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic        flush;

    logic        ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
    logic        ex_mem_read, ex_mem_write, ex_branch, ex_addi_op;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dst_reg;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic        stall, pc_write, if_id_write;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt, flush_cnt;
    logic [31:0] m_bubble, m_flush;
`endif

    ex_t  m;
    ex_t  exp_q[$];
    int   n_checks;
    int   n_pass;
    logic [9:0] ctrl_tbl [5];

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_reg_dst(id_ctrl[9]), .id_alu_src(id_ctrl[8]), .id_mem_to_reg(id_ctrl[7]),
        .id_reg_write(id_ctrl[6]), .id_mem_read(id_ctrl[5]), .id_mem_write(id_ctrl[4]),
        .id_branch(id_ctrl[3]), .id_addi_op(id_ctrl[0]), .id_alu_op(id_ctrl[2:1]),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .ex_valid(ex_valid),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_addi_op(ex_addi_op), .ex_alu_op(ex_alu_op),
        .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_dst_reg(ex_dst_reg),
`ifdef ID_EX_PERF_EN
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_ex(input ex_t e);
        check_eq("ex_valid",   64'(ex_valid), 64'(e.valid));
        check_eq("ex_ctrl",    64'({ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                                    ex_mem_write, ex_branch, ex_alu_op, ex_addi_op}), 64'(e.ctrl));
        check_eq("ex_regs",    64'({ex_funct, ex_rs, ex_rt, ex_rd}), 64'({e.funct, e.rs, e.rt, e.rd}));
        check_eq("ex_rs_data", 64'(ex_rs_data), 64'(e.rs_data));
        check_eq("ex_rt_data", 64'(ex_rt_data), 64'(e.rt_data));
        check_eq("ex_imm",     64'(ex_imm), 64'(e.imm));
        check_eq("ex_pc4",     64'(ex_pc4), 64'(e.pc4));
        check_eq("ex_dst_reg", 64'(ex_dst_reg), 64'(e.dst));
    endtask

    task automatic set_id(input logic v, input logic [9:0] c, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] imm, input logic fl);
        @(negedge clk);
        id_valid   = v;
        id_ctrl    = c;
        id_funct   = fn;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = 32'h1000_0000 + 32'(rs);
        id_rt_data = 32'h2000_0000 + 32'(rt);
        id_imm     = imm;
        id_pc4     = id_pc4 + 32'd4;
        flush      = fl;
    endtask

    // One clock: check hazard outputs, predict the EX register, then compare after the edge.
    task automatic cycle(input logic do_rst);
        logic exp_lu;
        logic exp_stall;
        ex_t  nxt;
        rst = do_rst;
        #1;
        exp_lu = m.valid && m.ctrl[5] && (m.rt != 5'd0) && id_valid &&
                 ((m.rt == id_rs) || ((id_ctrl[9] || id_ctrl[4] || id_ctrl[3]) && (m.rt == id_rt)));
        exp_stall = exp_lu && !flush;
        check_eq("stall",       64'(stall), 64'(exp_stall));
        check_eq("pc_write",    64'(pc_write), 64'(!exp_stall));
        check_eq("if_id_write", 64'(if_id_write), 64'(!exp_stall));
        nxt = m;
        if (do_rst) begin
            nxt = '0;
        end else if (flush) begin
            nxt.valid = 1'b0;
            nxt.ctrl  = C_NOP;
            nxt.dst   = 5'd0;
        end else if (exp_lu) begin
            nxt.valid = 1'b0;
            nxt.ctrl  = C_NOP;
        end else begin
            nxt = '{valid: id_valid, ctrl: (id_valid ? id_ctrl : C_NOP), funct: id_funct,
                    rs: id_rs, rt: id_rt, rd: id_rd, rs_data: id_rs_data, rt_data: id_rt_data,
                    imm: id_imm, pc4: id_pc4, dst: (id_ctrl[9] ? id_rd : id_rt)};
        end
`ifdef ID_EX_PERF_EN
        if (do_rst) begin
            m_bubble = 32'd0;
            m_flush  = 32'd0;
        end else begin
            if (exp_stall) m_bubble = m_bubble + 32'd1;
            if (flush && id_valid) m_flush = m_flush + 32'd1;
        end
`endif
        exp_q.push_back(nxt);
        m = nxt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_ex(exp_q.pop_front());
`ifdef ID_EX_PERF_EN
        check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
        check_eq("flush_cnt",  64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0; id_ctrl = C_NOP; id_funct = 6'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0; id_pc4 = 32'd0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m = '0;
        compare_ex(m);
`ifdef ID_EX_PERF_EN
        m_bubble = 32'd0;
        m_flush  = 32'd0;
        check_eq("bubble_cnt_rst", 64'(bubble_cnt), 64'd0);
        check_eq("flush_cnt_rst",  64'(flush_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("stall_rst",    64'(stall), 64'd0);
        check_eq("pc_write_rst", 64'(pc_write), 64'd1);
        check_eq("if_id_rst",    64'(if_id_write), 64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        id_pc4   = 32'd0;
        ctrl_tbl = '{C_R, C_LW, C_SW, C_BEQ, C_ADDI};
        do_reset();

        // addi $1,$0,5 ; add $2,$1,$1 ; nop
        set_id(1'b1, C_ADDI, 6'h00, 5'd0, 5'd1, 5'd0, 32'd5, 1'b0); cycle(1'b0);
        set_id(1'b1, C_R,    6'h20, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_NOP,  6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0); cycle(1'b0);

        // lw $3 ; add $4,$3,$5 -> one bubble, add captured on the retry
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_R,    6'h20, 5'd3, 5'd5, 5'd4, 32'd0, 1'b0); cycle(1'b0);
        id_pc4 = id_pc4 - 32'd4;
        set_id(1'b1, C_R,    6'h20, 5'd3, 5'd5, 5'd4, 32'd0, 1'b0); cycle(1'b0);

        // lw $0 never hazards
        set_id(1'b1, C_LW,   6'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0); cycle(1'b0);
        set_id(1'b1, C_R,    6'h20, 5'd0, 5'd0, 5'd4, 32'd0, 1'b0); cycle(1'b0);
        // lw $3 ; addi $6,$3,1 -> stall
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_ADDI, 6'h00, 5'd3, 5'd6, 5'd0, 32'd1, 1'b0); cycle(1'b0);
        id_pc4 = id_pc4 - 32'd4;
        set_id(1'b1, C_ADDI, 6'h00, 5'd3, 5'd6, 5'd0, 32'd1, 1'b0); cycle(1'b0);
        // lw $3 ; addi $3,$7,1 -> rt is a destination, no stall
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_ADDI, 6'h00, 5'd7, 5'd3, 5'd0, 32'd1, 1'b0); cycle(1'b0);
        // lw $3 ; sw $3,0($8) -> stall through rt
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_SW,   6'h00, 5'd8, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        // lw $3 ; invalid ID with matching rs -> no stall, controls forced to 0
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b0, C_R,    6'h20, 5'd3, 5'd3, 5'd9, 32'd0, 1'b0); cycle(1'b0);

        // load-use together with flush -> flush wins, no stall
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_R,    6'h20, 5'd3, 5'd5, 5'd4, 32'd0, 1'b1); cycle(1'b0);
        set_id(1'b1, C_BEQ,  6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 1'b1); cycle(1'b0);

        // reset on the edge of a stall clears everything
        set_id(1'b1, C_LW,   6'h00, 5'd0, 5'd3, 5'd0, 32'd0, 1'b0); cycle(1'b0);
        set_id(1'b1, C_R,    6'h20, 5'd3, 5'd5, 5'd4, 32'd0, 1'b0); cycle(1'b1);
        set_id(1'b1, C_R,    6'h20, 5'd3, 5'd5, 5'd4, 32'd0, 1'b0); cycle(1'b0);

        // small random mix on a narrow register range to provoke hazards
        for (int i = 0; i < 60; i++) begin
            set_id(($urandom_range(0, 7) != 0), ctrl_tbl[$urandom_range(0, 4)],
                   6'($urandom_range(0, 63)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 4) == 0));
            cycle(1'b0);
        end

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
